// File: rtl/phmem_ctl.sv
`default_nettype none
// ============================================================================
// Module   : phmem_ctl
// Brief    : Physical-memory cycle controller. Runs one wait-stated cycle on a
//            16-bit asynchronous SRAM per CPU request (translated address),
//            answering with a one-cycle reply or a write-protect fault.
//            All sequencing advances on clock-enable (ce) edges only.
// Revision : 1.0 - initial release
// ============================================================================
module phmem_ctl #(
  // Number of ce-cycles the SRAM strobe is held in ACCESS; legal 1..15.
  parameter int WAIT_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        ce,
  input  logic        req_rd,
  input  logic        req_wr,
  input  logic        req_byte,
  input  logic [15:0] req_data_i,
  input  logic [21:0] phaddr,
  input  logic        writable_i,
  output logic        rply_o,
  output logic        fault_o,
  output logic [15:0] data_o,
  output logic        busy_o,
  output logic [20:0] sram_addr,
  output logic [15:0] sram_dq_o,
  output logic        sram_dq_oe,
  input  logic [15:0] sram_dq_i,
  output logic        sram_ce_n,
  output logic        sram_oe_n,
  output logic        sram_we_n,
  output logic        sram_ub_n,
  output logic        sram_lb_n
);

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_SETUP   = 3'd1,
    S_ACCESS  = 3'd2,
    S_HOLD    = 3'd3,
    S_DONE    = 3'd4,
    S_FAULT   = 3'd5,
    S_WAITREL = 3'd6
  } state_t;

  state_t      state;
  state_t      state_nx;
  logic [3:0]  wait_cnt;
  logic        is_wr;      // direction latched at the sampling edge
  logic        dir_wr;     // direction valid on the edge that computes strobes
  logic        nx_cycle;   // next state drives the SRAM (SETUP/ACCESS/HOLD)
  logic        start;      // IDLE sampling edge that launches an SRAM cycle
  logic [7:0]  byte_sel;   // write byte picked from the addressed lane

  // Next-state logic; request inputs only matter in IDLE and WAITREL.
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE: begin
        if (req_rd && req_wr)           state_nx = S_FAULT;
        else if (req_wr && !writable_i) state_nx = S_FAULT;
        else if (req_rd || req_wr)      state_nx = S_SETUP;
      end
      S_SETUP:   state_nx = S_ACCESS;
      S_ACCESS:  if (wait_cnt == 4'd0) state_nx = S_HOLD;
      S_HOLD:    state_nx = S_DONE;
      S_DONE:    state_nx = S_WAITREL;
      S_FAULT:   state_nx = S_WAITREL;
      S_WAITREL: if (!req_rd && !req_wr) state_nx = S_IDLE;
      default:   state_nx = S_IDLE;
    endcase
  end

  // Helper terms shared by the registered strobe logic.
  always_comb begin
    start    = (state == S_IDLE) && (state_nx == S_SETUP);
    // At the sampling edge the latched direction is not yet valid.
    dir_wr   = (state == S_IDLE) ? req_wr : is_wr;
    nx_cycle = (state_nx == S_SETUP) || (state_nx == S_ACCESS) ||
               (state_nx == S_HOLD);
    byte_sel = phaddr[0] ? req_data_i[15:8] : req_data_i[7:0];
  end

  // State register and wait counter.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= S_IDLE;
      wait_cnt <= 4'd0;
    end else if (ce) begin
      state <= state_nx;
      if (state == S_SETUP)
        wait_cnt <= WAIT_LOAD;
      else if (state == S_ACCESS && wait_cnt != 4'd0)
        wait_cnt <= wait_cnt - 4'd1;
    end
  end

  // Request latch: address, direction, lanes and write data.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      is_wr     <= 1'b0;
      sram_addr <= '0;
      sram_dq_o <= '0;
      sram_ub_n <= 1'b1;
      sram_lb_n <= 1'b1;
    end else if (ce) begin
      if (start) begin
        is_wr     <= req_wr;
        sram_addr <= phaddr[21:1];
        // Word access enables both lanes; a byte access only its own lane.
        sram_ub_n <= req_byte & ~phaddr[0];
        sram_lb_n <= req_byte &  phaddr[0];
        if (req_wr)
          sram_dq_o <= req_byte ? {byte_sel, byte_sel} : req_data_i;
      end else if (!nx_cycle) begin
        sram_ub_n <= 1'b1;
        sram_lb_n <= 1'b1;
      end
    end
  end

  // Registered SRAM strobes, status and pulses, derived from the next state.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sram_ce_n  <= 1'b1;
      sram_oe_n  <= 1'b1;
      sram_we_n  <= 1'b1;
      sram_dq_oe <= 1'b0;
      busy_o     <= 1'b0;
      rply_o     <= 1'b0;
      fault_o    <= 1'b0;
    end else if (ce) begin
      sram_ce_n  <= ~nx_cycle;
      sram_oe_n  <= ~(!dir_wr && (state_nx == S_SETUP || state_nx == S_ACCESS));
      sram_we_n  <= ~(dir_wr && state_nx == S_ACCESS);
      sram_dq_oe <= dir_wr && nx_cycle;
      busy_o     <= (state_nx != S_IDLE);
      rply_o     <= (state_nx == S_DONE);
      // The fault pulse follows the FAULT state by one ce-cycle.
      fault_o    <= (state == S_FAULT);
    end
  end

  // Read data capture on the final ACCESS edge; held until the next read.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_o <= '0;
    end else if (ce) begin
      if (state == S_ACCESS && wait_cnt == 4'd0 && !is_wr)
        data_o <= sram_dq_i;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_phmem_ctl.sv
`default_nettype none
// ============================================================================
// Module   : tb_phmem_ctl
// Brief    : Self-checking bench for phmem_ctl with SRAM model and scoreboard.
//            A second instance (WAIT_CYCLES=3) is used for the ce-throttle case.
// Revision : 1.0 - initial release
// ============================================================================
module tb_phmem_ctl;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        ce = 1'b1;
  logic        ce3 = 1'b0;
  logic        mode3 = 1'b0;
  logic        req_rd = 1'b0, req_wr = 1'b0, req_byte = 1'b0, writable = 1'b0;
  logic [15:0] req_data = '0;
  logic [21:0] phaddr = '0;

  logic        rply, fault, busy, dq_oe, ce_n, oe_n, we_n, ub_n, lb_n;
  logic [15:0] data, dq_o, dq_i;
  logic [20:0] addr;
  logic        rply3, fault3, busy3, dq_oe3, ce_n3, oe_n3, we_n3, ub_n3, lb_n3;
  logic [15:0] data3, dq_o3, dq_i3;
  logic [20:0] addr3;

  phmem_ctl #(.WAIT_CYCLES(2)) u_dut (
    .clk(clk), .reset_n(reset_n), .ce(ce), .req_rd(req_rd), .req_wr(req_wr),
    .req_byte(req_byte), .req_data_i(req_data), .phaddr(phaddr),
    .writable_i(writable), .rply_o(rply), .fault_o(fault), .data_o(data),
    .busy_o(busy), .sram_addr(addr), .sram_dq_o(dq_o), .sram_dq_oe(dq_oe),
    .sram_dq_i(dq_i), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_ub_n(ub_n), .sram_lb_n(lb_n)
  );

  phmem_ctl #(.WAIT_CYCLES(3)) u_dut3 (
    .clk(clk), .reset_n(reset_n), .ce(ce3), .req_rd(req_rd), .req_wr(req_wr),
    .req_byte(req_byte), .req_data_i(req_data), .phaddr(phaddr),
    .writable_i(writable), .rply_o(rply3), .fault_o(fault3), .data_o(data3),
    .busy_o(busy3), .sram_addr(addr3), .sram_dq_o(dq_o3), .sram_dq_oe(dq_oe3),
    .sram_dq_i(dq_i3), .sram_ce_n(ce_n3), .sram_oe_n(oe_n3), .sram_we_n(we_n3),
    .sram_ub_n(ub_n3), .sram_lb_n(lb_n3)
  );

  always #5 clk = ~clk;

  // Clock enables: main instance runs every clock, the throttled one every other.
  always @(negedge clk) begin
    if (mode3) begin ce = 1'b0; ce3 = ~ce3; end
    else       begin ce = 1'b1; ce3 = 1'b0; end
  end

  // Observation mux: selected instance.
  logic m_rply, m_fault, m_busy, m_we_n, m_ce_n, m_ce;
  logic [15:0] m_data;
  assign m_rply  = mode3 ? rply3  : rply;
  assign m_fault = mode3 ? fault3 : fault;
  assign m_busy  = mode3 ? busy3  : busy;
  assign m_we_n  = mode3 ? we_n3  : we_n;
  assign m_ce_n  = mode3 ? ce_n3  : ce_n;
  assign m_ce    = mode3 ? ce3    : ce;
  assign m_data  = mode3 ? data3  : data;

  // SRAM models.
  logic [15:0] mem [0:255];
  assign dq_i  = (!ce_n && !oe_n) ? mem[addr[7:0]] : 16'hDEAD;
  assign dq_i3 = (!ce_n3 && !oe_n3) ? 16'h5A5A : 16'hDEAD;
  always @(posedge clk) begin
    if (!ce_n && !we_n) begin
      if (!ub_n) mem[addr[7:0]][15:8] <= dq_o[15:8];
      if (!lb_n) mem[addr[7:0]][7:0]  <= dq_o[7:0];
    end
  end

  // Checking.
  int n_checks = 0, n_pass = 0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  // Scoreboard.
  typedef struct { logic is_fault; logic chk_data; logic [15:0] data; } exp_t;
  exp_t sb[$];
  logic [15:0] ref_mem [0:255];
  int n_events = 0, n_rply = 0, n_sram_cyc = 0;
  logic prev_r = 1'b0, prev_f = 1'b0, prev_cen = 1'b1;

  task automatic on_event(input logic is_f);
    exp_t e;
    n_events++;
    if (!is_f) n_rply++;
    if (sb.size() == 0) check("unexpected_event", 32'(is_f), 32'hFFFF);
    else begin
      e = sb.pop_front();
      check("event_kind", 32'(is_f), 32'(e.is_fault));
      if (!is_f && e.chk_data) check("rd_data", 32'(m_data), 32'(e.data));
    end
  endtask

  // Monitor: pulse rising edges and main-SRAM cycle starts.
  always begin
    @(posedge clk); #1;
    if (m_rply && !prev_r)  on_event(1'b0);
    if (m_fault && !prev_f) on_event(1'b1);
    if (!ce_n && prev_cen)  n_sram_cyc++;
    prev_r = m_rply; prev_f = m_fault; prev_cen = ce_n;
  end

  int resp_edge, we_clks, ce_low, pulse_clks;
  logic [15:0] snap_dq;
  logic snap_ub, snap_lb;

  task automatic do_cycle(input logic rd, input logic wr, input logic bt,
                          input logic [21:0] a, input logic [15:0] d,
                          input logic wok, input int hold_clks);
    exp_t e;
    int idx;
    logic cc, done, idle;
    logic [7:0] b;
    e.is_fault = (rd && wr) || (wr && !wok);
    e.chk_data = rd && !wr && !mode3 || (rd && !wr && mode3);
    e.data = mode3 ? 16'h5A5A : ref_mem[a[8:1]];
    if (wr && !rd && wok && !mode3) begin
      b = a[0] ? d[15:8] : d[7:0];
      if (!bt)       ref_mem[a[8:1]] = d;
      else if (a[0]) ref_mem[a[8:1]][15:8] = b;
      else           ref_mem[a[8:1]][7:0] = b;
    end
    sb.push_back(e);
    @(negedge clk);
    req_rd = rd; req_wr = wr; req_byte = bt; phaddr = a; req_data = d; writable = wok;
    idx = -1; resp_edge = -1; we_clks = 0; ce_low = 0; pulse_clks = 0; done = 1'b0;
    for (int k = 0; k < 400 && !done; k++) begin
      @(posedge clk); cc = m_ce; #1;
      if (cc) idx++;
      if (!m_we_n) begin
        we_clks++; snap_dq = dq_o; snap_ub = ub_n; snap_lb = lb_n;
      end
      if (!m_ce_n) ce_low++;
      if (m_rply || m_fault) begin
        pulse_clks++;
        if (resp_edge < 0) resp_edge = idx;
      end else if (resp_edge >= 0) done = 1'b1;
    end
    if (!done) check("cycle_timeout", 32'd0, 32'd1);
    repeat (hold_clks) @(negedge clk);
    @(negedge clk);
    req_rd = 1'b0; req_wr = 1'b0;
    idle = 1'b0;
    for (int k = 0; k < 50 && !idle; k++) begin
      @(posedge clk); #1;
      if (!m_busy) idle = 1'b1;
    end
    if (!idle) check("idle_timeout", 32'd0, 32'd1);
  endtask

  int ev0, rp0, sc0;
  logic seen;

  initial begin
    for (int i = 0; i < 256; i++) begin mem[i] = 16'h0000; ref_mem[i] = 16'h0000; end
    #23;
    // Reset state.
    check("rst_rply", 32'(rply), 32'd0);
    check("rst_fault", 32'(fault), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(data), 32'd0);
    check("rst_addr", 32'(addr), 32'd0);
    check("rst_strobes", {27'd0, ce_n, oe_n, we_n, ub_n, lb_n}, 32'h1F);
    check("rst_dq", {15'd0, dq_oe, dq_o}, 32'd0);
    @(negedge clk); reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // Word write then read back.
    do_cycle(1'b0, 1'b1, 1'b0, 22'h000100, 16'h1234, 1'b1, 0);
    check("wr_rply_edge", 32'(resp_edge), 32'd4);
    check("wr_we_width", 32'(we_clks), 32'd2);
    check("wr_addr", 32'(addr), 32'h00080);
    check("wr_pulse_len", 32'(pulse_clks), 32'd1);
    do_cycle(1'b1, 1'b0, 1'b0, 22'h000100, 16'h0000, 1'b1, 0);
    check("rd_rply_edge", 32'(resp_edge), 32'd4);
    check("rd_word", 32'(data), 32'h1234);

    // Byte write, odd address (upper lane).
    do_cycle(1'b0, 1'b1, 1'b1, 22'h000101, 16'hABAB, 1'b1, 0);
    check("bodd_lanes", {30'd0, snap_ub, snap_lb}, 32'b01);
    check("bodd_dq", 32'(snap_dq), 32'hABAB);
    check("bodd_mem", 32'(mem[8'h80]), 32'hAB34);

    // Byte write, even address (lower lane), then read the word.
    do_cycle(1'b0, 1'b1, 1'b1, 22'h000200, 16'h77CD, 1'b1, 0);
    check("beven_lanes", {30'd0, snap_ub, snap_lb}, 32'b10);
    check("beven_dq", 32'(snap_dq), 32'hCDCD);
    do_cycle(1'b1, 1'b0, 1'b0, 22'h000200, 16'h0000, 1'b1, 0);

    // Write-protect fault: no SRAM activity, data_o unchanged.
    sc0 = n_sram_cyc; rp0 = n_rply;
    do_cycle(1'b0, 1'b1, 1'b0, 22'h000100, 16'hFFFF, 1'b0, 0);
    check("wp_fault_edge", 32'(resp_edge), 32'd1);
    check("wp_pulse_len", 32'(pulse_clks), 32'd1);
    check("wp_no_ce", 32'(ce_low), 32'd0);
    check("wp_data_hold", 32'(data), 32'h00CD);
    // Read and write together.
    do_cycle(1'b1, 1'b1, 1'b0, 22'h000100, 16'hFFFF, 1'b1, 0);
    check("rdwr_fault_edge", 32'(resp_edge), 32'd1);
    check("fault_no_sram", 32'(n_sram_cyc - sc0), 32'd0);
    check("fault_no_rply", 32'(n_rply - rp0), 32'd0);
    // Protected word must be untouched.
    do_cycle(1'b1, 1'b0, 1'b0, 22'h000100, 16'h0000, 1'b0, 0);

    // Held request: exactly one cycle.
    sc0 = n_sram_cyc; rp0 = n_rply;
    do_cycle(1'b1, 1'b0, 1'b0, 22'h000200, 16'h0000, 1'b1, 20);
    check("held_one_rply", 32'(n_rply - rp0), 32'd1);
    check("held_one_sram", 32'(n_sram_cyc - sc0), 32'd1);

    // Reset during ACCESS of a write.
    @(negedge clk);
    req_wr = 1'b1; req_byte = 1'b0; phaddr = 22'h000300; req_data = 16'hBEEF; writable = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 50 && !seen; k++) begin
      @(posedge clk); #1;
      if (!we_n) seen = 1'b1;
    end
    check("rst_mid_reach_access", 32'(seen), 32'd1);
    ev0 = n_events;
    #2 reset_n = 1'b0;
    #1;
    check("rst_mid_strobes", {29'd0, we_n, ce_n, dq_oe}, 32'b110);
    check("rst_mid_busy", 32'(busy), 32'd0);
    req_wr = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    repeat (10) @(negedge clk);
    check("rst_mid_no_pulse", 32'(n_events - ev0), 32'd0);

    // Clock-enable throttle on the WAIT_CYCLES=3 instance.
    mode3 = 1'b1;
    repeat (3) @(negedge clk);
    do_cycle(1'b1, 1'b0, 1'b0, 22'h000040, 16'h0000, 1'b1, 0);
    check("thr_rply_edge", 32'(resp_edge), 32'd5);
    check("thr_pulse_clks", 32'(pulse_clks), 32'd2);
    check("thr_ce_width", 32'(ce_low), 32'd10);
    do_cycle(1'b0, 1'b1, 1'b0, 22'h000040, 16'h1111, 1'b1, 0);
    check("thr_we_width", 32'(we_clks), 32'd6);
    mode3 = 1'b0;

    repeat (4) @(negedge clk);
    check("sb_drained", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
